// File: rtl/fpnew_rob_pkg.sv
// Shared types for the FPU reorder-buffer wrapper: status flags, ROB entry layout
// and the control-bundle packing helper.
package fpnew_rob_pkg;

   // Entry storage widths; FLEN and USER_WIDTH of the wrapper must not exceed these.
   localparam int ROB_FLEN   = 64;
   localparam int ROB_USER_W = 2;
   localparam int ROB_CTRL_W = 16;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [ROB_USER_W-1:0] user;
      logic [ROB_FLEN-1:0]   result;
      status_t               status;
   } rob_entry_t;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100,
      DYN = 3'b111
   } roundmode_e;

   typedef enum logic [3:0] {
      FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
      CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
   } operation_e;

   typedef enum logic [1:0] {
      FP32, FP64, FP16, FP8
   } fp_format_e;

   typedef enum logic [1:0] {
      INT8, INT16, INT32, INT64
   } int_format_e;

   // Bit 15 is spare; the rest mirrors the FPU's decode order from LSB upward.
   function automatic logic [ROB_CTRL_W-1:0] pack_ctrl(
      input roundmode_e  rnd_mode,
      input operation_e  op,
      input logic        op_mod,
      input fp_format_e  src_fmt,
      input fp_format_e  dst_fmt,
      input int_format_e int_fmt,
      input logic        vectorial
   );
      return {1'b0, vectorial, int_fmt, dst_fmt, src_fmt, op_mod, op, rnd_mode};
   endfunction

endpackage

// File: rtl/fpnew_rob_wrapper.sv
// In-order completion layer: tags requests to an out-of-order FPU, collects results
// in a reorder buffer and retires them in issue order; flush bumps the tag epoch.
module fpnew_rob_wrapper
   import fpnew_rob_pkg::*;
#(
   parameter  int FLEN         = ROB_FLEN,
   parameter  int NUM_OPERANDS = 3,
   parameter  int CTRL_WIDTH   = 16,
   parameter  int DEPTH        = 4,
   parameter  int USER_WIDTH   = ROB_USER_W,
   localparam int IDX_W        = $clog2(DEPTH)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [NUM_OPERANDS*FLEN-1:0] operands_i,
   input  logic [CTRL_WIDTH-1:0]        ctrl_i,
   input  logic [USER_WIDTH-1:0]        user_i,
   input  logic                         flush_i,
   output logic                         core_valid_o,
   input  logic                         core_ready_i,
   output logic [NUM_OPERANDS*FLEN-1:0] core_operands_o,
   output logic [CTRL_WIDTH-1:0]        core_ctrl_o,
   output logic [IDX_W:0]               core_tag_o,
   output logic                         core_flush_o,
   input  logic                         resp_valid_i,
   input  logic [IDX_W:0]               resp_tag_i,
   input  logic [FLEN-1:0]              resp_result_i,
   input  logic [4:0]                   resp_status_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [FLEN-1:0]              out_result_o,
   output logic [4:0]                   out_status_o,
   output logic [USER_WIDTH-1:0]        out_user_o,
   output logic                         busy_o,
   output logic                         err_o
);

   rob_entry_t       rob_q [DEPTH];
   logic [IDX_W-1:0] head_q;
   logic [IDX_W-1:0] tail_q;
   logic [IDX_W:0]   count_q;
   logic             epoch_q;
   logic             err_q;

   rob_entry_t       head_entry;
   logic [IDX_W-1:0] resp_idx;
   logic             full;
   logic             fire;
   logic             retire;
   logic             resp_hit;
   logic             resp_live;
   logic             resp_ok;
   logic             resp_bad;

   // Full uses the registered count so a same-cycle retire never opens a slot.
   assign full = (count_q == (IDX_W+1)'(DEPTH));

   assign in_ready_o      = core_ready_i & ~full & ~flush_i;
   assign core_valid_o    = in_valid_i & rst_ni & ~full & ~flush_i;
   assign fire            = core_valid_o & core_ready_i;
   assign core_operands_o = operands_i;
   assign core_ctrl_o     = ctrl_i;
   assign core_tag_o      = {epoch_q, tail_q};
   assign core_flush_o    = flush_i;

   // Responses from an older epoch are stale and ignored without complaint.
   assign resp_idx  = resp_tag_i[IDX_W-1:0];
   assign resp_hit  = resp_valid_i & ~flush_i & (resp_tag_i[IDX_W] == epoch_q);
   assign resp_live = rob_q[resp_idx].valid & ~rob_q[resp_idx].done;
   assign resp_ok   = resp_hit & resp_live;
   assign resp_bad  = resp_hit & ~resp_live;

   assign head_entry   = rob_q[head_q];
   assign out_valid_o  = head_entry.valid & head_entry.done & ~flush_i;
   assign retire       = out_valid_o & out_ready_i;
   assign out_result_o = head_entry.result[FLEN-1:0];
   assign out_status_o = head_entry.status;
   assign out_user_o   = head_entry.user[USER_WIDTH-1:0];
   assign busy_o       = (count_q != '0);
   assign err_o        = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         epoch_q <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i] <= '0;
         end
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         epoch_q <= ~epoch_q;
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i].valid <= 1'b0;
            rob_q[i].done  <= 1'b0;
         end
      end else begin
         if (resp_bad) begin
            err_q <= 1'b1;
         end
         if (fire) begin
            tail_q <= tail_q + IDX_W'(1);
         end
         if (retire) begin
            head_q <= head_q + IDX_W'(1);
         end
         if (fire && !retire) begin
            count_q <= count_q + (IDX_W+1)'(1);
         end else if (retire && !fire) begin
            count_q <= count_q - (IDX_W+1)'(1);
         end
         // Response, alloc and retire always hit distinct entries when they coincide.
         for (int i = 0; i < DEPTH; i++) begin
            if (resp_ok && resp_idx == IDX_W'(i)) begin
               rob_q[i].done   <= 1'b1;
               rob_q[i].result <= ROB_FLEN'(resp_result_i);
               rob_q[i].status <= resp_status_i;
            end
            if (fire && tail_q == IDX_W'(i)) begin
               rob_q[i].valid <= 1'b1;
               rob_q[i].done  <= 1'b0;
               rob_q[i].user  <= ROB_USER_W'(user_i);
            end
            if (retire && head_q == IDX_W'(i)) begin
               rob_q[i].valid <= 1'b0;
               rob_q[i].done  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpnew_rob_wrapper.sv
// Bench for fpnew_rob_wrapper: directed scenarios with literal expectations plus a
// randomized run, all checked against a queue-based in-order completion model.
module tb_fpnew_rob_wrapper;
   import fpnew_rob_pkg::*;

   localparam int FLEN  = 64;
   localparam int NOP   = 3;
   localparam int CW    = 16;
   localparam int DEPTH = 4;
   localparam int UW    = 2;
   localparam int IW    = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [NOP*FLEN-1:0] operands = '0;
   logic [CW-1:0]     ctrl = '0;
   logic [UW-1:0]     user = '0;
   logic              flush = 1'b0;
   logic              core_valid;
   logic              core_ready = 1'b0;
   logic [NOP*FLEN-1:0] core_operands;
   logic [CW-1:0]     core_ctrl;
   logic [IW:0]       core_tag;
   logic              core_flush;
   logic              resp_valid = 1'b0;
   logic [IW:0]       resp_tag = '0;
   logic [FLEN-1:0]   resp_result = '0;
   logic [4:0]        resp_status = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [FLEN-1:0]   out_result;
   logic [4:0]        out_status;
   logic [UW-1:0]     out_user;
   logic              busy;
   logic              err;

   always #5 clk = ~clk;

   fpnew_rob_wrapper #(
      .FLEN(FLEN), .NUM_OPERANDS(NOP), .CTRL_WIDTH(CW), .DEPTH(DEPTH), .USER_WIDTH(UW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .operands_i(operands), .ctrl_i(ctrl), .user_i(user), .flush_i(flush),
      .core_valid_o(core_valid), .core_ready_i(core_ready),
      .core_operands_o(core_operands), .core_ctrl_o(core_ctrl),
      .core_tag_o(core_tag), .core_flush_o(core_flush),
      .resp_valid_i(resp_valid), .resp_tag_i(resp_tag),
      .resp_result_i(resp_result), .resp_status_i(resp_status),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_result_o(out_result), .out_status_o(out_status), .out_user_o(out_user),
      .busy_o(busy), .err_o(err)
   );

   // Model: in-flight operations in issue order, each remembering the slot it was tagged with.
   typedef struct {
      logic [IW-1:0] idx;
      logic [UW-1:0] user;
      bit            done;
      logic [63:0]   res;
      logic [4:0]    st;
   } ment_t;

   ment_t mq[$];
   bit    m_ep = 1'b0;
   bit    m_err = 1'b0;
   int    m_tail = 0;
   bit    e_fire, e_retire;
   int    n_cmp = 0;
   int    n_fail = 0;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_compare();
      bit            full, exp_ir, exp_cv, exp_ov;
      logic [IW-1:0] ti;
      full   = (mq.size() == DEPTH);
      exp_ir = core_ready && !full && !flush;
      exp_cv = in_valid && rst_n && !full && !flush;
      exp_ov = !flush && mq.size() > 0 && mq[0].done;
      ti     = IW'(m_tail);
      chk("in_ready", in_ready, exp_ir);
      chk("core_valid", core_valid, exp_cv);
      chk("core_tag", core_tag, {m_ep, ti});
      chk("core_flush", core_flush, flush);
      chk("core_operands", core_operands, operands);
      chk("core_ctrl", core_ctrl, ctrl);
      chk("busy", busy, mq.size() != 0);
      chk("err", err, m_err);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
         chk("out_result", out_result, mq[0].res);
         chk("out_status", out_status, mq[0].st);
         chk("out_user", out_user, mq[0].user);
      end
      e_fire   = exp_cv && core_ready;
      e_retire = exp_ov && out_ready;
   endtask

   task automatic model_update();
      ment_t e;
      if (!rst_n) return;
      if (flush) begin
         mq.delete();
         m_ep   = !m_ep;
         m_tail = 0;
         return;
      end
      if (resp_valid && resp_tag[IW] == m_ep) begin
         int k;
         k = -1;
         foreach (mq[j]) if (mq[j].idx == resp_tag[IW-1:0]) k = j;
         if (k < 0 || mq[k].done) m_err = 1'b1;
         else begin
            mq[k].done = 1'b1;
            mq[k].res  = resp_result;
            mq[k].st   = resp_status;
         end
      end
      if (e_retire) void'(mq.pop_front());
      if (e_fire) begin
         e.idx  = IW'(m_tail);
         e.user = user;
         e.done = 1'b0;
         e.res  = '0;
         e.st   = '0;
         mq.push_back(e);
         m_tail = (m_tail + 1) % DEPTH;
      end
   endtask

   task automatic half();
      @(negedge clk);
      model_compare();
   endtask

   task automatic fin();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      in_valid = 1'b0; flush = 1'b0; resp_valid = 1'b0; out_ready = 1'b0; core_ready = 1'b1;
   endtask

   // Asserts reset between clock edges and checks the outputs drop without a clock.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      set_idle();
      mq.delete(); m_ep = 1'b0; m_err = 1'b0; m_tail = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      half(); fin();
      rst_n = 1'b1;
   endtask

   task automatic respond(input logic [IW:0] tag, input logic [63:0] res, input logic [4:0] st);
      resp_valid = 1'b1; resp_tag = tag; resp_result = res; resp_status = st;
   endtask

   initial begin
      int r, pk;
      int pend[$];

      // Reset state with a request already pending at the input
      in_valid = 1'b1; core_ready = 1'b1;
      operands = {6{32'h1234_5678}};
      half();
      chk("rst_core_valid", core_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid0", out_valid, 0);
      chk("rst_busy0", busy, 0);
      fin();
      rst_n = 1'b1;
      set_idle();

      // In-order completion
      in_valid = 1'b1; user = 2'd0; ctrl = pack_ctrl(RNE, ADD, 1'b0, FP64, FP64, INT32, 1'b0);
      half(); chk("t1_tag_a", core_tag, 0); fin();
      user = 2'd1; ctrl = pack_ctrl(RTZ, DIV, 1'b0, FP64, FP64, INT32, 1'b0);
      half(); chk("t1_tag_b", core_tag, 1); fin();
      in_valid = 1'b0;
      respond(0, 64'h3FF0000000000000, 5'b00000);
      half(); chk("t1_no_out", out_valid, 0); fin();
      respond(1, 64'h4000000000000000, 5'b00001);
      half(); chk("t1_a_valid", out_valid, 1); chk("t1_a_res", out_result, 64'h3FF0000000000000); fin();
      resp_valid = 1'b0; out_ready = 1'b1;
      half(); chk("t1_a_user", out_user, 0); fin();
      half(); chk("t1_b_res", out_result, 64'h4000000000000000); chk("t1_b_user", out_user, 1);
      chk("t1_b_status", out_status, 5'b00001); fin();
      out_ready = 1'b0;
      half(); chk("t1_busy_low", busy, 0); fin();

      // Out-of-order responses
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         user = UW'(i);
         half(); fin();
      end
      in_valid = 1'b0;
      respond(2, 64'hC, 5'b00010);
      half(); fin();
      respond(0, 64'hA, 5'b00100);
      half(); chk("t2_wait_tag0", out_valid, 0); fin();
      respond(1, 64'hB, 5'b01000); out_ready = 1'b1;
      half(); chk("t2_first", out_valid, 1); chk("t2_u0", out_user, 0); fin();
      resp_valid = 1'b0;
      half(); chk("t2_nobubble1", out_valid, 1); chk("t2_u1", out_user, 1); fin();
      half(); chk("t2_nobubble2", out_valid, 1); chk("t2_u2", out_user, 2); fin();
      half(); chk("t2_empty", busy, 0); fin();

      // Full and backpressure
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         user = UW'(i);
         half(); fin();
      end
      half(); chk("t3_full_ready", in_ready, 0); chk("t3_full_cvalid", core_valid, 0); fin();
      in_valid = 1'b0;
      respond(0, 64'h11, 5'b0);
      half(); fin();
      resp_valid = 1'b0; out_ready = 1'b1;
      half(); chk("t3_retire_v", out_valid, 1); chk("t3_ready_still0", in_ready, 0); fin();
      out_ready = 1'b0;
      half(); chk("t3_ready_rise", in_ready, 1); fin();
      respond(1, 64'h22, 5'b0);
      half(); fin();
      resp_valid = 1'b0; in_valid = 1'b1; user = 2'd3; out_ready = 1'b1;
      half(); chk("t3_both_v", out_valid, 1); chk("t3_both_ready", in_ready, 1); fin();
      in_valid = 1'b0; out_ready = 1'b0;
      half(); chk("t3_count3_ready", in_ready, 1); fin();
      in_valid = 1'b1;
      half(); fin();
      in_valid = 1'b0;
      half(); chk("t3_full_again", in_ready, 0); fin();

      // Flush with stale response, then async reset with live entries
      do_reset();
      in_valid = 1'b1;
      half(); fin(); half(); fin();
      flush = 1'b1;
      half(); chk("t4_flush_out", core_flush, 1); chk("t4_flush_cvalid", core_valid, 0); fin();
      flush = 1'b0; in_valid = 1'b0;
      half(); chk("t4_busy0", busy, 0); fin();
      respond(0, 64'hDEAD, 5'b11111);
      half(); fin();
      resp_valid = 1'b0;
      half(); chk("t4_stale_noerr", err, 0); chk("t4_stale_noout", out_valid, 0); fin();
      in_valid = 1'b1;
      half(); chk("t4_new_tag", core_tag, 3'b100); fin();
      half(); fin(); half(); fin();
      in_valid = 1'b0;
      respond(3'b100, 64'h55, 5'b0);
      half(); fin();
      half(); fin();
      resp_valid = 1'b0;
      half(); chk("t6_pre_v", out_valid, 1); chk("t6_pre_busy", busy, 1); chk("t6_pre_err", err, 1); fin();
      do_reset();
      half(); chk("t6_epoch0", core_tag, 0); fin();

      // Duplicate response
      do_reset();
      in_valid = 1'b1;
      half(); fin();
      in_valid = 1'b0;
      respond(0, 64'h1111, 5'b0);
      half(); fin();
      respond(0, 64'h2222, 5'b10000);
      half(); chk("t5_err_before", err, 0); fin();
      resp_valid = 1'b0;
      half(); chk("t5_err", err, 1); chk("t5_keep_first", out_result, 64'h1111); fin();
      half(); chk("t5_err_sticky", err, 1); fin();

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if (c % 600 == 599) do_reset();
         in_valid   = ($urandom_range(0, 99) < 60);
         user       = UW'($urandom);
         operands   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         ctrl       = CW'($urandom);
         core_ready = ($urandom_range(0, 99) < 85);
         out_ready  = ($urandom_range(0, 99) < 70);
         flush      = ($urandom_range(0, 99) < 2);
         resp_valid = 1'b0;
         resp_result = {$urandom, $urandom};
         resp_status = 5'($urandom);
         pend.delete();
         foreach (mq[j]) if (!mq[j].done) pend.push_back(j);
         r = $urandom_range(0, 99);
         if (r < 50 && pend.size() > 0) begin
            pk = pend[$urandom_range(0, pend.size() - 1)];
            resp_valid = 1'b1;
            resp_tag   = {m_ep, mq[pk].idx};
         end else if (r < 58) begin
            resp_valid = 1'b1;
            resp_tag   = {!m_ep, IW'($urandom)};
         end else if (r < 60) begin
            resp_valid = 1'b1;
            resp_tag   = {m_ep, IW'($urandom)};
         end
         half(); fin();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fpnew_rob_wrapper.md
Name: fpnew_rob_wrapper

Overview:
- Parametrised in-order completion layer for FPU cores whose results can return out of order, e.g. a PARALLEL ADDMUL alongside an iterative MERGED DIVSQRT.
- Accepts requests from the issuing core and forwards them to an external FPU through a tagged request/response port.
- Collects results by tag in a DEPTH-entry reorder buffer and retires them strictly in issue order, returning the caller's opaque user tag.
- Supports flush with epoch-based discard of stale responses.

Parameters:
- FLEN, 64, operand/result width per operand.
- NUM_OPERANDS, 3, operands per request.
- CTRL_WIDTH, 16, packed control bundle width (rnd_mode, op, op_mod, src/dst/int fmt, vectorial); passed through unmodified.
- DEPTH, 4, ROB entries; power of two, >= 2.
- USER_WIDTH, 2, caller tag width.
- IDX_W, $clog2(DEPTH), derived; not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i & in_ready_o.
- operands_i  in  NUM_OPERANDS*FLEN  operands.
- ctrl_i  in  CTRL_WIDTH  control bundle.
- user_i  in  USER_WIDTH  caller tag.
- flush_i  in  1  discard all in-flight work.
- core_valid_o  out  1  request to FPU.
- core_ready_i  in  1  FPU accepts.
- core_operands_o  out  NUM_OPERANDS*FLEN  = operands_i.
- core_ctrl_o  out  CTRL_WIDTH  = ctrl_i.
- core_tag_o  out  IDX_W+1  {epoch, tail index}.
- core_flush_o  out  1  = flush_i.
- resp_valid_i  in  1  FPU result valid.
- resp_tag_i  in  IDX_W+1  echoed core tag.
- resp_result_i  in  FLEN  result.
- resp_status_i  in  5  NV,DZ,OF,UF,NX.
- out_valid_o  out  1  head result valid.
- out_ready_i  in  1  consumer ready.
- out_result_o  out  FLEN  head result.
- out_status_o  out  5  head status.
- out_user_o  out  USER_WIDTH  head caller tag.
- busy_o  out  1  count != 0.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_ni low):
  - head = tail = count = 0; epoch = 0; all entry valid/done bits 0.
  - Outputs: out_valid_o = 0, busy_o = 0, err_o = 0, core_valid_o = 0 (because in_valid_i is gated by the reset state), in_ready_o = core_ready_i. Data outputs are don't-care but are zero after reset.
- Full: full = (count == DEPTH). Full is computed from the registered count, so an accept is not enabled by a same-cycle retire.
- Issue (combinational pass-through, zero added latency):
  - core_valid_o = in_valid_i & !full & !flush_i.
  - in_ready_o = core_ready_i & !full & !flush_i.
  - On fire: entry[tail] gets valid = 1, done = 0, user = user_i; tail++ (wraps modulo DEPTH); core_tag_o = {epoch, tail}.
- Response: resp_ready is implicit; responses are always accepted.
  - Matching response: resp_valid_i, resp_tag_i epoch == epoch, entry valid, not done. Store result and status, set done. Visible at out_* the next cycle at the earliest.
  - Epoch mismatch: silently dropped, no error.
  - Epoch match but entry not valid, or entry already done: dropped and err_o set; err_o clears only on reset.
- Retire: out_valid_o = entry[head].valid & entry[head].done & !flush_i; out_* read entry[head]. On out_valid_o & out_ready_i: clear entry[head], head++.
- Count:
  - Alloc only: +1.
  - Retire only: -1.
  - Both in the same cycle: unchanged.
  - Allowed simultaneous events: response write, alloc and retire in one cycle, each to distinct entries or to the head entry.
  - A response arriving for the head entry in the same cycle it would retire cannot happen, since the head is not done in that cycle.
- Flush (single cycle, priority over everything):
  - Clear all valid/done bits; head = tail = count = 0; epoch toggles.
  - No accept and no retire in the flush cycle; responses in the flush cycle are dropped.
  - core_flush_o is asserted in the same cycle; the FPU may still return old-epoch responses afterwards, and these are discarded.
- Stall: out_* hold stable while out_valid_o & !out_ready_i.

Decomposition:
- Package fpnew_rob_pkg holds:
  - status_t, a 5-bit packed struct identical in layout to the FPU status.
  - rob_entry_t {valid, done, user, result, status}.
  - ctrl bundle packing helper: a function that packs the fpnew_pkg enums into CTRL_WIDTH.
- Single module; no sub-module. The entry array is a flop array of rob_entry_t indexed by head/tail.

Test Plan:
- In-order: DEPTH=4; issue A(user 0), B(user 1); respond tag 0 then 1 with results 0x3FF0000000000000 and 0x4000000000000000 -> outputs in that order with users 0,1; busy_o falls after the second retire.
- Out-of-order: issue 3 ops; respond tags 2,0,1 on consecutive cycles -> out_valid_o first rises the cycle after tag 0 arrives; retire order is user 0,1,2; no bubble once all are done with out_ready_i high.
- Full/backpressure: issue 4 with no responses -> in_ready_o = 0 while the 5th request is held. Respond to tag 0 and retire it -> in_ready_o rises the next cycle. Alloc and retire in the same cycle at count 3 -> count stays 3.
- Flush with stale response: 2 in flight at epoch 0; flush_i one cycle -> busy_o = 0 next cycle. Then respond tag {0,0} -> dropped, err_o stays 0. New request gets core_tag_o = {1,0}.
- Protocol error: respond twice to the same live tag -> err_o = 1 and stays 1; the first result is preserved.
- Async reset mid-operation: assert rst_ni low between clock edges with 3 entries live -> out_valid_o, busy_o and err_o drop immediately; epoch returns to 0.
